// File: rtl/ahbl_lsu_bridge.sv
// Ibex-style req/gnt/rvalid/err port to AHB-Lite master; combinational address phase, rvalid 1 cycle after gnt plus slave wait states.
// Backpressure: gnt_o held low while hready_i=0 or during the second HRESP error cycle; the core holds its request.
module ahbl_lsu_bridge #(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter bit         INSTR_MODE = 1'b0,
    parameter logic [3:0] HPROT_VAL  = 4'b0011,
    localparam int        BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_cpu,
    input  logic                  rstn_cpu,
    input  logic                  req_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic                  err_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [BE_WIDTH-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [2:0]            hburst_o,
    output logic                  hmastlock_o,
    output logic [3:0]            hprot_o,
    output logic [2:0]            hsize_o,
    output logic [1:0]            htrans_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    output logic                  hwrite_o,
    input  logic [DATA_WIDTH-1:0] hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    localparam int         OFF_W     = $clog2(BE_WIDTH);
    localparam logic [2:0] FULL_SIZE = 3'($clog2(BE_WIDTH));
    localparam logic [3:0] HPROT_EFF = INSTR_MODE ? (HPROT_VAL & 4'b1110) : HPROT_VAL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            dec_size;
    logic [OFF_W-1:0]      dec_off;
    logic                  gnt;
    logic                  done;

    // Gated by reset so every output is quiet while rstn_cpu is low.
    assign gnt  = rstn_cpu && req_i && hready_i && (state_q != ERR1);
    assign done = (state_q != IDLE) && hready_i;

    // Narrowest naturally aligned transfer covering the byte enables.
    always_comb begin
        dec_size = FULL_SIZE;
        dec_off  = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be_i == (BE_WIDTH'(1) << i)) begin
                dec_size = 3'b000;
                dec_off  = OFF_W'(i);
            end
        end
        for (int i = 0; i < BE_WIDTH; i += 2) begin
            if (be_i == (BE_WIDTH'(3) << i)) begin
                dec_size = 3'b001;
                dec_off  = OFF_W'(i);
            end
        end
        if (BE_WIDTH == 8) begin
            for (int i = 0; i < BE_WIDTH; i += 4) begin
                if (be_i == (BE_WIDTH'(15) << i)) begin
                    dec_size = 3'b010;
                    dec_off  = OFF_W'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (gnt) state_d = DATA;
            DATA: begin
                if (hready_i)     state_d = gnt ? DATA : IDLE;
                else if (hresp_i) state_d = ERR1;
            end
            ERR1: if (hready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_cpu or negedge rstn_cpu) begin
        if (!rstn_cpu) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (gnt) begin
                we_q    <= we_i && !INSTR_MODE;
                wdata_q <= INSTR_MODE ? '0 : wdata_i;
            end
        end
    end

    assign gnt_o       = gnt;
    assign rvalid_o    = done;
    assign err_o       = done && ((state_q == ERR1) || hresp_i);
    assign rdata_o     = (done && !err_o && !we_q) ? hrdata_i : '0;

    assign htrans_o    = gnt ? 2'b10 : 2'b00;
    assign haddr_o     = !gnt ? '0 :
                         INSTR_MODE ? addr_i : {addr_i[ADDR_WIDTH-1:OFF_W], dec_off};
    assign hsize_o     = !gnt ? 3'b000 : (INSTR_MODE ? FULL_SIZE : dec_size);
    assign hwrite_o    = gnt && we_i && !INSTR_MODE;
    assign hprot_o     = gnt ? HPROT_EFF : 4'b0000;
    assign hburst_o    = 3'b000;
    assign hmastlock_o = 1'b0;
    assign hwdata_o    = ((state_q != IDLE) && we_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ahbl_lsu_bridge.sv
// Bench for ahbl_lsu_bridge: data-mode instance checked every cycle against a transaction model,
// plus directed literal checks on both the data-mode and instruction-mode instances.
module tb_ahbl_lsu_bridge;

    logic        clk_cpu = 1'b0;
    logic        rstn_cpu;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    logic        gnt, rvalid, err, hmastlock, hwrite;
    logic [31:0] rdata, haddr, hwdata;
    logic [2:0]  hburst, hsize;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    logic        i_gnt, i_rvalid, i_err, i_hmastlock, i_hwrite;
    logic [31:0] i_rdata, i_haddr, i_hwdata;
    logic [2:0]  i_hburst, i_hsize;
    logic [3:0]  i_hprot;
    logic [1:0]  i_htrans;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_cpu = ~clk_cpu;

    ahbl_lsu_bridge #(.INSTR_MODE(1'b0)) dut (
        .clk_cpu(clk_cpu), .rstn_cpu(rstn_cpu), .req_i(req), .gnt_o(gnt),
        .rvalid_o(rvalid), .err_o(err), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .rdata_o(rdata), .haddr_o(haddr), .hburst_o(hburst),
        .hmastlock_o(hmastlock), .hprot_o(hprot), .hsize_o(hsize), .htrans_o(htrans),
        .hwdata_o(hwdata), .hwrite_o(hwrite), .hrdata_i(hrdata), .hready_i(hready),
        .hresp_i(hresp)
    );

    ahbl_lsu_bridge #(.INSTR_MODE(1'b1)) dut_i (
        .clk_cpu(clk_cpu), .rstn_cpu(rstn_cpu), .req_i(req), .gnt_o(i_gnt),
        .rvalid_o(i_rvalid), .err_o(i_err), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .rdata_o(i_rdata), .haddr_o(i_haddr), .hburst_o(i_hburst),
        .hmastlock_o(i_hmastlock), .hprot_o(i_hprot), .hsize_o(i_hsize), .htrans_o(i_htrans),
        .hwdata_o(i_hwdata), .hwrite_o(i_hwrite), .hrdata_i(hrdata), .hready_i(hready),
        .hresp_i(hresp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected HSIZE/offset from byte enables: contiguous run of 1, 2 or 4 bytes aligned to its own size.
    function automatic void exp_dec(input logic [3:0] b, output logic [2:0] sz, output logic [1:0] off);
        int cnt;
        int low;
        cnt = $countones(b);
        low = 0;
        for (int i = 3; i >= 0; i--) if (b[i]) low = i;
        sz  = 3'd2;
        off = 2'd0;
        if ((cnt == 1 || cnt == 2 || cnt == 4) && (low % cnt) == 0 &&
            ((b >> low) == 4'((1 << cnt) - 1))) begin
            sz  = (cnt == 1) ? 3'd0 : (cnt == 2) ? 3'd1 : 3'd2;
            off = 2'(low);
        end
    endfunction

    // Transaction model: at most one outstanding data phase.
    logic        m_pend = 1'b0, m_we = 1'b0, m_err = 1'b0;
    logic [31:0] m_wdata = '0;

    always @(negedge clk_cpu) begin
        logic       e_gnt, e_done, e_err;
        logic [2:0] sz;
        logic [1:0] off;
        exp_dec(be, sz, off);
        e_gnt  = rstn_cpu && req && hready && !m_err;
        e_done = rstn_cpu && m_pend && hready;
        e_err  = e_done && (m_err || hresp);
        chk("gnt", gnt, e_gnt);
        chk("rvalid", rvalid, e_done);
        chk("err", err, e_err);
        chk("rdata", rdata, (e_done && !e_err && !m_we) ? hrdata : 32'h0);
        chk("hwdata", hwdata, (rstn_cpu && m_pend && m_we) ? m_wdata : 32'h0);
        chk("htrans", htrans, e_gnt ? 2'b10 : 2'b00);
        chk("haddr", haddr, e_gnt ? {addr[31:2], off} : 32'h0);
        chk("hsize", hsize, e_gnt ? sz : 3'd0);
        chk("hwrite", hwrite, e_gnt && we);
        chk("hprot", hprot, e_gnt ? 4'b0011 : 4'b0000);
        chk("hburst_hmastlock", {hburst, hmastlock}, 4'd0);
        if (!rstn_cpu) begin
            m_pend = 1'b0;
            m_err  = 1'b0;
            m_we   = 1'b0;
        end else begin
            if (m_pend && !hready && hresp) m_err = 1'b1;
            if (e_done) begin
                m_pend = 1'b0;
                m_err  = 1'b0;
            end
            if (e_gnt) begin
                m_pend  = 1'b1;
                m_we    = we;
                m_wdata = wdata;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, then return at the falling edge.
    task automatic cyc(input logic rs, input logic rq, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] wd, input logic hr,
                       input logic hp, input logic [31:0] rd);
        @(posedge clk_cpu);
        #1;
        rstn_cpu = rs; req = rq; addr = a; we = w; be = b; wdata = wd;
        hready = hr; hresp = hp; hrdata = rd;
        @(negedge clk_cpu);
    endtask

    initial begin
        rstn_cpu = 1'b0; req = 1'b1; addr = 32'h40; we = 1'b0; be = 4'hF;
        wdata = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;

        // Reset held with a live request
        cyc(0, 1, 32'h40, 0, 4'hF, 0, 1, 0, 0);
        cyc(0, 1, 32'h40, 0, 4'hF, 0, 1, 0, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_htrans", htrans, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_i_hprot", i_hprot, 0);

        cyc(1, 1, 32'h40, 0, 4'hF, 0, 1, 0, 0);
        chk("first_gnt", gnt, 1);
        chk("first_haddr", haddr, 32'h40);
        chk("first_hsize", hsize, 3'b010);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'hCAFEF00D);
        chk("first_rvalid", rvalid, 1);
        chk("first_rdata", rdata, 32'hCAFEF00D);

        // Byte write
        cyc(1, 1, 32'h1000, 1, 4'b0100, 32'hAABBCCDD, 1, 0, 0);
        chk("bw_haddr", haddr, 32'h1002);
        chk("bw_hsize", hsize, 3'b000);
        chk("bw_hwrite", hwrite, 1);
        chk("instr_hwrite", i_hwrite, 0);
        chk("instr_hsize", i_hsize, 3'b010);
        chk("instr_hprot", i_hprot, 4'b0010);
        chk("instr_haddr", i_haddr, 32'h1000);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h5A5A);
        chk("bw_hwdata", hwdata, 32'hAABBCCDD);
        chk("bw_rvalid", rvalid, 1);
        chk("bw_err", err, 0);
        chk("bw_rdata", rdata, 0);
        chk("instr_hwdata", i_hwdata, 0);

        // Read with three wait states; a held request is not granted meanwhile
        cyc(1, 1, 32'h2000, 0, 4'hF, 0, 1, 0, 0);
        chk("ws_gnt", gnt, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 32'h3000, 0, 4'hF, 0, 0, 0, 32'hDEAD);
            chk("ws_rvalid", rvalid, 0);
            chk("ws_gnt_blocked", gnt, 0);
        end
        cyc(1, 1, 32'h3000, 0, 4'hF, 0, 1, 0, 32'h12345678);
        chk("ws_rvalid_4th", rvalid, 1);
        chk("ws_rdata", rdata, 32'h12345678);
        chk("ws_overlap_gnt", gnt, 1);

        // Back-to-back reads 0x0, 0x4, 0x8
        for (int i = 0; i < 4; i++) begin
            cyc(1, i < 3, 32'(4 * i), 0, 4'hF, 0, 1, 0, 32'(32'h100 + i));
            chk("b2b_gnt", gnt, (i < 3));
            if (i < 3) chk("b2b_haddr", haddr, 32'(4 * i));
            chk("b2b_rvalid", rvalid, 1);
            chk("b2b_rdata", rdata, 32'(32'h100 + i));
        end

        // Two-cycle error response
        cyc(1, 1, 32'h500, 1, 4'b0011, 32'h55, 1, 0, 0);
        chk("err_hsize", hsize, 3'b001);
        chk("err_haddr", haddr, 32'h500);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("err1_rvalid", rvalid, 0);
        chk("err1_hwdata", hwdata, 32'h55);
        cyc(1, 1, 32'h600, 0, 4'hF, 0, 1, 1, 32'hBEEF);
        chk("err2_gnt", gnt, 0);
        chk("err2_htrans", htrans, 0);
        chk("err2_rvalid", rvalid, 1);
        chk("err2_err", err, 1);
        chk("err2_rdata", rdata, 0);
        cyc(1, 1, 32'h600, 0, 4'hF, 0, 1, 0, 0);
        chk("post_err_gnt", gnt, 1);
        chk("post_err_rvalid", rvalid, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h77);
        chk("post_err_rdata", rdata, 32'h77);
        chk("post_err_err", err, 0);

        // Further byte-enable decode cases
        cyc(1, 1, 32'h700, 1, 4'b1100, 32'h1, 1, 0, 0);
        chk("dec_hi_pair_addr", haddr, 32'h702);
        chk("dec_hi_pair_size", hsize, 3'b001);
        cyc(1, 1, 32'h700, 1, 4'b1000, 32'h2, 1, 0, 0);
        chk("dec_b3_addr", haddr, 32'h703);
        chk("dec_b3_size", hsize, 3'b000);
        cyc(1, 1, 32'h700, 1, 4'b0110, 32'h3, 1, 0, 0);
        chk("dec_unaligned_addr", haddr, 32'h700);
        chk("dec_unaligned_size", hsize, 3'b010);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset during a stalled data phase drops the response
        cyc(1, 1, 32'h800, 0, 4'hF, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'h99);
        chk("midrst_rvalid", rvalid, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h99);
        chk("midrst_no_rvalid", rvalid, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
